// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one iteration per cycle.
// Latency: accept -> done_o after XLEN+2 cycles (2 cycles for early-out cases with MULDIV_EARLY_OUT_EN).
// Backpressure: busy_o stalls EX while working; start_i is only sampled in IDLE, flush_i aborts.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    typedef struct packed {
        logic [2:0]      funct3;
        logic            neg_q;
        logic            neg_r;
        logic            special;
        logic [XLEN-1:0] special_val;
    } op_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    op_t               op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_init, acc_iter;
    logic [XLEN-1:0]   opb_q, opb_init;
    logic [XLEN-1:0]   result_q, fix_val;

    logic              accept, early_out;
    logic              is_div, sign_a, sign_b, neg_a, neg_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;

    assign accept = (state_q == IDLE) && start_i && !flush_i;

    // Operand decode at accept time; operands are reduced to magnitudes plus result signs.
    always_comb begin
        is_div   = funct3_i[2];
        sign_a   = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                   (funct3_i == 3'b100) || (funct3_i == 3'b110);
        sign_b   = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        neg_a    = sign_a && rs1_i[XLEN-1];
        neg_b    = sign_b && rs2_i[XLEN-1];
        mag_a    = neg_a ? -rs1_i : rs1_i;
        mag_b    = neg_b ? -rs2_i : rs2_i;
        div_zero = is_div && (rs2_i == '0);
        div_ovf  = ((funct3_i == 3'b100) || (funct3_i == 3'b110)) &&
                   (rs1_i == MIN_NEG) && (rs2_i == '1);

        op_d             = '0;
        op_d.funct3      = funct3_i;
        op_d.neg_q       = neg_a ^ neg_b;
        op_d.neg_r       = neg_a;
        op_d.special     = div_zero || div_ovf;
        op_d.special_val = '0;
        if (div_zero)
            op_d.special_val = funct3_i[1] ? rs1_i : '1;
        else if (div_ovf)
            op_d.special_val = funct3_i[1] ? '0 : MIN_NEG;

`ifdef MULDIV_EARLY_OUT_EN
        // A zero-operand multiply yields zero, so special_val stays at its zero default.
        if (!is_div && ((rs1_i == '0) || (rs2_i == '0)))
            op_d.special = 1'b1;
        early_out = op_d.special;
`else
        early_out = 1'b0;
`endif

        // Multiply: hi=partial product, lo=multiplier. Divide: hi=remainder, lo=dividend/quotient.
        acc_init = is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
        opb_init = is_div ? mag_b : mag_a;
    end

    // One iteration of shift-add or restoring division on the shared accumulator.
    logic [XLEN:0] mul_sum, div_shift, div_diff;
    logic          div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = !div_diff[XLEN];
        if (op_q.funct3[2])
            acc_iter = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ge};
        else
            acc_iter = {mul_sum, acc_q[XLEN-1:1]};
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    always_comb begin
        prod_fix = op_q.neg_q ? -acc_q : acc_q;
        quo_fix  = op_q.neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = op_q.neg_r ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q.funct3)
            3'b000:                 fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quo_fix;
            default:                fix_val = rem_fix;
        endcase
        if (op_q.special)
            fix_val = op_q.special_val;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = early_out ? FIX : CALC;
            CALC: begin
                if (flush_i)
                    state_d = IDLE;
                else if (cnt_q == CNT_W'(XLEN - 1))
                    state_d = FIX;
            end
            FIX:  state_d = flush_i ? IDLE : DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            if ((state_q == CALC) && !flush_i)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;

            if (accept) begin
                op_q  <= op_d;
                acc_q <= acc_init;
                opb_q <= opb_init;
            end else if ((state_q == CALC) && !flush_i) begin
                acc_q <= acc_iter;
            end

            if ((state_q == FIX) && !flush_i)
                result_q <= fix_val;
        end
    end

    assign busy_o   = (state_q == CALC) || (state_q == FIX);
    assign done_o   = (state_q == DONE) && !flush_i;
    assign result_o = result_q;

endmodule
